// File: rtl/prescaler_tick_gen.sv
// prescaler_tick_gen
// Turns one runtime-selectable bit of a free-running prescaler count into a
// single-cycle enable strobe. A new tap is requested with a valid/ready
// handshake. It takes over only when both the old and new taps are at a
// common wrap point, so no tick is lost, doubled or glitched.
//
// Ports
//   clk         system clock (shared with the upstream prescaler)
//   reset       synchronous, active-high
//   prescaler   count vector from clock_prescaler
//   sel_in      requested tap index (clamped to WIDTH-1)
//   sel_valid   request valid; accepted when sel_valid && sel_ready
//   sel_ready   high while no request is pending
//   sel_active  tap currently driving tick
//   tick        one-cycle strobe on a rising edge of prescaler[sel_active]
//   tick_count  emitted ticks modulo 2**CNTW
module prescaler_tick_gen #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SELW  = 5,
   parameter int unsigned CNTW  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] prescaler,
   input  logic [SELW-1:0]  sel_in,
   input  logic             sel_valid,
   output logic             sel_ready,
   output logic [SELW-1:0]  sel_active,
   output logic             tick,
   output logic [CNTW-1:0]  tick_count
);

   localparam logic [0:0]  IDLE    = 1'b0;
   localparam logic [0:0]  PENDING = 1'b1;
   localparam int unsigned MAX_SEL = WIDTH - 1;

   logic [0:0]      state;
   logic [0:0]      state_nxt;
   logic [SELW-1:0] pend;
   logic [SELW-1:0] pend_nxt;
   logic            prev_bit;

   logic            tap_bit_c;
   logic [SELW-1:0] req_c;
   logic [SELW-1:0] hi_c;
   logic            wrap_c;
   logic            switch_c;

   // Current tap value, clamped request and the higher of the two taps.
   always_comb begin
      tap_bit_c = prescaler[sel_active];
      req_c     = (32'(sel_in) > MAX_SEL) ? SELW'(MAX_SEL) : sel_in;
      hi_c      = (sel_active > pend) ? sel_active : pend;
   end

   // Wrap point: every prescaler bit up to and including hi_c is zero.
   always_comb begin
      wrap_c = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if ((i <= int'(hi_c)) && prescaler[i]) begin
            wrap_c = 1'b0;
         end
      end
   end

   // Next-state logic for the tap-select handshake.
   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      switch_c  = 1'b0;
      case (state)
         IDLE: begin
            if (sel_valid) begin
               pend_nxt  = req_c;
               state_nxt = PENDING;
            end
         end
         PENDING: begin
            if (wrap_c) begin
               switch_c  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register; sel_ready mirrors the next state so it is high in IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pend      <= '0;
         sel_ready <= 1'b1;
      end else begin
         state     <= state_nxt;
         pend      <= pend_nxt;
         sel_ready <= (state_nxt == IDLE);
      end
   end

   // Edge detect, tap switch and tick counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_active <= '0;
         prev_bit   <= 1'b0;
         tick       <= 1'b0;
         tick_count <= '0;
      end else begin
         tick       <= !prev_bit && tap_bit_c;
         tick_count <= tick_count + CNTW'(tick);
         if (switch_c) begin
            // Both taps are low here, so clearing prev_bit cannot fake an edge.
            sel_active <= pend;
            prev_bit   <= 1'b0;
         end else begin
            prev_bit   <= tap_bit_c;
         end
      end
   end

endmodule

// File: tb/tb_prescaler_tick_gen.sv
module tb_prescaler_tick_gen;

   typedef struct {
      int unsigned active;
      int unsigned pend;
      int unsigned cnt;
      bit          pending;
      bit          prev;
      bit          tick;
   } m_t;

   typedef struct {
      bit          rst;
      logic [31:0] psc;
      logic [4:0]  sel;
      bit          vld;
      bit          tick;
      logic [4:0]  active;
      bit          ready;
      logic [15:0] cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] psc;
   logic [4:0]  sel;
   logic        vld;

   logic        rdy, tck;
   logic [4:0]  act;
   logic [15:0] cnt;
   logic        rdy4, tck4;
   logic [4:0]  act4;
   logic [3:0]  cnt4;

   int n_vec = 0;
   int n_err = 0;
   m_t m32;
   m_t m20;
   vec_t tbl[13];

   always #5 clk = ~clk;

   prescaler_tick_gen #(.WIDTH(32), .SELW(5), .CNTW(16)) dut (
      .clk(clk), .reset(rst), .prescaler(psc), .sel_in(sel), .sel_valid(vld),
      .sel_ready(rdy), .sel_active(act), .tick(tck), .tick_count(cnt)
   );

   prescaler_tick_gen #(.WIDTH(20), .SELW(5), .CNTW(4)) dut4 (
      .clk(clk), .reset(rst), .prescaler(psc[19:0]), .sel_in(sel), .sel_valid(vld),
      .sel_ready(rdy4), .sel_active(act4), .tick(tck4), .tick_count(cnt4)
   );

   task automatic check(input string name, input int unsigned actual, input int unsigned expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference behaviour: tick on a 0->1 of the selected tap, counted modulo
   // 2**cw; a pending tap takes over once the count is a multiple of
   // 2**(max(active,pend)+1).
   task automatic model_step(inout m_t m, input int unsigned w, input int unsigned cw,
                             input bit r, input logic [31:0] p, input logic [4:0] s, input bit v);
      bit              b;
      int unsigned     hi;
      longint unsigned span;
      if (r) begin
         m = '{default: 0};
         return;
      end
      b      = p[m.active];
      m.cnt  = (m.cnt + (m.tick ? 1 : 0)) % (1 << cw);
      m.tick = !m.prev && b;
      if (m.pending) begin
         hi   = (m.active > m.pend) ? m.active : m.pend;
         span = 64'd1 << (hi + 1);
         if ((64'(p) % span) == 0) begin
            m.active  = m.pend;
            m.prev    = 1'b0;
            m.pending = 1'b0;
         end else begin
            m.prev = b;
         end
      end else begin
         m.prev = b;
         if (v) begin
            if (int'(s) > int'(w) - 1) m.pend = w - 1;
            else                       m.pend = int'(s);
            m.pending = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_step(m32, 32, 16, rst, psc, sel, vld);
      model_step(m20, 20, 4, rst, psc & 32'h000F_FFFF, sel, vld);
      check("tick32",   32'(tck),  32'(m32.tick));
      check("active32", 32'(act),  m32.active);
      check("ready32",  32'(rdy),  32'(!m32.pending));
      check("count32",  32'(cnt),  m32.cnt);
      check("tick20",   32'(tck4), 32'(m20.tick));
      check("active20", 32'(act4), m20.active);
      check("ready20",  32'(rdy4), 32'(!m20.pending));
      check("count20",  32'(cnt4), m20.cnt);
   endtask

   initial begin
      m32 = '{default: 0};
      m20 = '{default: 0};
      rst = 1'b1; psc = '0; sel = '0; vld = 1'b0;

      // rst psc sel vld | tick active ready cnt
      tbl[0]  = '{1,  0, 0, 0, 0, 0, 1, 0};
      tbl[1]  = '{0,  0, 0, 0, 0, 0, 1, 0};
      tbl[2]  = '{0,  1, 0, 0, 1, 0, 1, 0};
      tbl[3]  = '{0,  2, 0, 0, 0, 0, 1, 1};
      tbl[4]  = '{0,  3, 0, 0, 1, 0, 1, 1};
      tbl[5]  = '{0,  4, 0, 0, 0, 0, 1, 2};
      tbl[6]  = '{0,  5, 1, 1, 1, 0, 0, 2};
      tbl[7]  = '{0,  6, 7, 1, 0, 0, 0, 3};
      tbl[8]  = '{0,  7, 0, 0, 1, 0, 0, 3};
      tbl[9]  = '{0,  8, 0, 0, 0, 1, 1, 4};
      tbl[10] = '{0,  9, 0, 0, 0, 1, 1, 4};
      tbl[11] = '{0, 10, 0, 0, 1, 1, 1, 4};
      tbl[12] = '{0, 11, 0, 0, 0, 1, 1, 5};

      for (int i = 0; i < 13; i++) begin
         rst = tbl[i].rst; psc = tbl[i].psc; sel = tbl[i].sel; vld = tbl[i].vld;
         step();
         check($sformatf("tbl%0d_tick", i),   32'(tck), 32'(tbl[i].tick));
         check($sformatf("tbl%0d_active", i), 32'(act), 32'(tbl[i].active));
         check($sformatf("tbl%0d_ready", i),  32'(rdy), 32'(tbl[i].ready));
         check($sformatf("tbl%0d_count", i),  32'(cnt), 32'(tbl[i].cnt));
      end

      // Reset while a request is pending; a second request is ignored meanwhile.
      sel = 5'd4; vld = 1'b1; psc = 32'd12; step();
      check("t6_ready_pending", 32'(rdy), 0);
      sel = 5'd2; vld = 1'b1; psc = 32'd13; step();
      check("t6_active_hold", 32'(act), 1);
      check("t6_ready_hold",  32'(rdy), 0);
      rst = 1'b1; vld = 1'b0; psc = 32'd17; step();
      check("t6_active_rst", 32'(act), 0);
      check("t6_ready_rst",  32'(rdy), 1);
      check("t6_tick_rst",   32'(tck), 0);
      check("t6_count_rst",  32'(cnt), 0);

      // Tick counter wrap on the CNTW=4 instance.
      rst = 1'b0;
      for (int p = 0; p <= 32; p++) begin
         psc = 32'(p); step();
      end
      check("t5_count4_wrap", 32'(cnt4), 0);
      check("t5_count16",     32'(cnt),  16);
      psc = 32'd33; step();
      psc = 32'd34; step();
      check("t5_count4_after", 32'(cnt4), 1);
      check("t5_count16_after", 32'(cnt), 17);

      // Out-of-range request clamps to WIDTH-1 on the WIDTH=20 instance;
      // bits above the taps are ignored for the wrap test.
      rst = 1'b1; step();
      rst = 1'b0; sel = 5'd25; vld = 1'b1; psc = 32'd1; step();
      vld = 1'b0; psc = 32'd2; step();
      psc = 32'h0010_0000; step();
      check("t4_active20_clamp", 32'(act4), 19);
      check("t4_ready20",        32'(rdy4), 1);
      check("t4_ready32_wait",   32'(rdy),  0);
      check("t4_active32_wait",  32'(act),  0);
      psc = 32'd0; step();
      check("t4_active32", 32'(act), 25);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) psc = 32'($urandom) << $urandom_range(0, 32);
         else                            psc = psc + 32'd1;
         vld = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) sel = 5'($urandom);
         else                           sel = 5'($urandom_range(0, 5));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
